// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH valid/ready slices with flush,
// bubble-zeroed control, occupancy and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 10,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt,
  input  logic                       stall_clr
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_src_valid;
  logic [DEPTH-1:0] w_valid_next;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stalled;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slice
      logic [DATA_W-1:0] r_data;
      logic [CTRL_W-1:0] r_ctrl;
      logic [DATA_W-1:0] w_src_data;
      logic [CTRL_W-1:0] w_src_ctrl;

      if (gi == 0) begin : g_head
        assign w_src_valid[gi] = in_valid;
        assign w_src_data      = in_data;
        assign w_src_ctrl      = in_ctrl;
      end else begin : g_chain
        assign w_src_valid[gi] = r_valid[gi-1];
        assign w_src_data      = g_slice[gi-1].r_data;
        assign w_src_ctrl      = g_slice[gi-1].r_ctrl;
      end

      // Ready ripples backwards from the output so a full pipe can still shift.
      if (gi == DEPTH-1) begin : g_tail_rdy
        assign w_ready[gi] = ~r_valid[gi] | out_ready;
      end else begin : g_mid_rdy
        assign w_ready[gi] = ~r_valid[gi] | w_ready[gi+1];
      end

      assign w_valid_next[gi] = flush ? 1'b0 : (w_ready[gi] ? w_src_valid[gi] : r_valid[gi]);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_data <= '0;
          r_ctrl <= '0;
        end else if (flush) begin
          r_ctrl <= '0;
        end else if (w_ready[gi]) begin
          r_data <= w_src_data;
          r_ctrl <= w_src_valid[gi] ? w_src_ctrl : '0;
        end
      end
    end
  endgenerate

  always_comb begin
    w_occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_next = w_occ_next + OCC_W'(w_valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_occ   <= w_occ_next;
    end
  end

  assign w_stalled = r_valid[DEPTH-1] & ~out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stalled && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = g_slice[DEPTH-1].r_data;
  assign out_ctrl  = g_slice[DEPTH-1].r_ctrl & {CTRL_W{r_valid[DEPTH-1]}};
  assign occupancy = r_occ;
  assign stall_cnt = r_stall_cnt;

endmodule
